alu_result_collector: RTL
=========================

Name: alu_result_collector

Overview:
Downstream stage of the ALU execution units (arithmetic, logic, compare, shift). Samples the registered unit outputs and their one-hot valid flags every clock. Tags each result with its source unit and buffers it in a small show-ahead FIFO. Drains the FIFO to the consumer over a valid/ready handshake. Counts results dropped on overflow and flags protocol violations.

Parameters:
DATA_WIDTH, 16, width of every unit result and of RESULT_OUT
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2
DROP_CNT_WIDTH, 8, width of the saturating drop counter

Ports:
Clk  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-low
ARITH_OUT  input  DATA_WIDTH  arithmetic unit result
ARITH_FLAG  input  1  arithmetic result valid this cycle
LOGIC_OUT  input  DATA_WIDTH  logic unit result
LOGIC_FLAG  input  1  logic result valid
CMP_OUT  input  DATA_WIDTH  compare unit result
CMP_FLAG  input  1  compare result valid
SHIFT_OUT  input  DATA_WIDTH  shift unit result
SHIFT_FLAG  input  1  shift result valid
OUT_READY  input  1  consumer accepts head entry this cycle
RESULT_OUT  output  DATA_WIDTH  head entry data
RESULT_SRC  output  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift
RESULT_VALID  output  1  FIFO non-empty
FIFO_COUNT  output  log2(FIFO_DEPTH)+1  current occupancy
DROP_COUNT  output  DROP_CNT_WIDTH  results lost to overflow, saturating
MULTI_ERR  output  1  sticky: more than one FLAG was high in the same cycle

Behaviour:
- Reset (RST low, asynchronous): pointers, count, DROP_COUNT and MULTI_ERR clear to 0. RESULT_VALID is 0. The storage array is not reset. RESULT_OUT and RESULT_SRC read 0 while empty (masked with RESULT_VALID).
- Reset mid-operation discards all buffered entries. No partial state survives.
- Write request: any FLAG high at a rising edge.
- Priority when several flags are high: arith > logic > cmp > shift. Only the highest-priority result is written. MULTI_ERR sets at that edge and holds until reset.
- Pop: RESULT_VALID & OUT_READY at a rising edge. OUT_READY while empty is ignored.
- FIFO is show-ahead. RESULT_OUT, RESULT_SRC and RESULT_VALID come straight from registered state with no combinational path from the inputs.
- Latency: a flag sampled at edge E into an empty FIFO gives RESULT_VALID=1 with that data immediately after E.
- Pointers wrap modulo FIFO_DEPTH. FIFO_COUNT = writes − pops, in the range 0..FIFO_DEPTH.
- Full with a write and no pop: the write is dropped, the FIFO is unchanged, and DROP_COUNT increments, saturating at all-ones.
- Full with a write and a pop in the same cycle: both occur. Count stays FIFO_DEPTH and nothing is dropped.
- Empty with a write and OUT_READY high: the write occurs and nothing pops that cycle (RESULT_VALID was 0). Count goes to 1.
- Simultaneous write and pop at non-boundary occupancy: count unchanged.
- Control is a 3-state tracker derived from count: EMPTY (count 0), PARTIAL, FULL (count FIFO_DEPTH).
  - EMPTY→PARTIAL on a write.
  - PARTIAL→FULL on a write without a pop at count FIFO_DEPTH−1.
  - PARTIAL→EMPTY on a pop without a write at count 1.
  - FULL→PARTIAL on a pop without a write.

Optional Feature:
- Macro: ALU_COLLECT_PARITY_EN.
- When defined: adds output port RESULT_PAR (1 bit).
  - Each entry stores the even-parity bit, XOR of {src, data}, computed at write time.
  - RESULT_PAR presents the head entry's parity and reads 0 while empty.
  - Storage widens by 1 bit.
- When undefined: the port and the storage bit do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset and single result: deassert RST, pulse SHIFT_FLAG with SHIFT_OUT=16'h00A4 for one cycle, OUT_READY=1 → next cycle RESULT_VALID=1, RESULT_OUT=16'h00A4, RESULT_SRC=2'b11; cycle after that RESULT_VALID=0, FIFO_COUNT=0.
- Fill and overflow: OUT_READY=0, six consecutive ARITH_FLAG pulses with data 1..6 → FIFO_COUNT=4, DROP_COUNT=2. Then OUT_READY=1 pops 1,2,3,4 in order, all with RESULT_SRC=00.
- Full with simultaneous write and pop: FIFO full with 1..4, one edge with LOGIC_FLAG (data 16'h0055) and OUT_READY=1 → 1 popped, count stays 4, DROP_COUNT unchanged, drain order 2,3,4,16'h0055.
- Multi-flag: CMP_FLAG and SHIFT_FLAG high together, CMP_OUT=16'h0001, SHIFT_OUT=16'h0F00 → one entry 16'h0001 with src 10. MULTI_ERR=1 and stays 1 after later clean traffic until RST.
- Reset mid-operation: 3 entries buffered, RST pulsed low between clock edges → RESULT_VALID, FIFO_COUNT, DROP_COUNT and MULTI_ERR go 0 immediately. After release, a new entry with data 16'h7777 is output first.
- Parity (with ALU_COLLECT_PARITY_EN): LOGIC_FLAG with data 16'h0003 → RESULT_PAR = XOR of 01 and 0003 = 1. DROP_COUNT saturation: 260 overflow writes → DROP_COUNT=8'hFF.

Source files
------------

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - priority-tagged show-ahead result FIFO behind the ALU units (optional RESULT_PAR via ALU_COLLECT_PARITY_EN)
module alu_result_collector #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                          Clk,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         ARITH_OUT,
    input  logic                          ARITH_FLAG,
    input  logic [DATA_WIDTH-1:0]         LOGIC_OUT,
    input  logic                          LOGIC_FLAG,
    input  logic [DATA_WIDTH-1:0]         CMP_OUT,
    input  logic                          CMP_FLAG,
    input  logic [DATA_WIDTH-1:0]         SHIFT_OUT,
    input  logic                          SHIFT_FLAG,
    input  logic                          OUT_READY,
    output logic [DATA_WIDTH-1:0]         RESULT_OUT,
    output logic [1:0]                    RESULT_SRC,
    output logic                          RESULT_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic [DROP_CNT_WIDTH-1:0]     DROP_COUNT,
`ifdef ALU_COLLECT_PARITY_EN
    output logic                          RESULT_PAR,
`endif
    output logic                          MULTI_ERR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef ALU_COLLECT_PARITY_EN
    localparam int EW = DATA_WIDTH + 3;
`else
    localparam int EW = DATA_WIDTH + 2;
`endif
    localparam logic [CW-1:0]             CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]             CNT_ALMOST = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
    localparam logic [AW-1:0]             PTR_ONE   = AW'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE  = DROP_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                      state;
    logic [EW-1:0]               mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt;
    logic                        multi_err;

    logic                        wr_req;
    logic                        multi_hit;
    logic [1:0]                  wr_src;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [EW-1:0]               wr_entry;
    logic                        pop;
    logic                        do_wr;
    logic                        drop;
    logic [EW-1:0]               head;

    // Pick the highest-priority unit result (arith > logic > cmp > shift) and note collisions
    always_comb begin
        wr_src    = 2'b00;
        wr_data   = '0;
        wr_req    = ARITH_FLAG | LOGIC_FLAG | CMP_FLAG | SHIFT_FLAG;
        multi_hit = (32'(ARITH_FLAG) + 32'(LOGIC_FLAG) + 32'(CMP_FLAG) + 32'(SHIFT_FLAG)) > 32'd1;
        if (ARITH_FLAG) begin
            wr_src  = 2'b00;
            wr_data = ARITH_OUT;
        end else if (LOGIC_FLAG) begin
            wr_src  = 2'b01;
            wr_data = LOGIC_OUT;
        end else if (CMP_FLAG) begin
            wr_src  = 2'b10;
            wr_data = CMP_OUT;
        end else if (SHIFT_FLAG) begin
            wr_src  = 2'b11;
            wr_data = SHIFT_OUT;
        end
`ifdef ALU_COLLECT_PARITY_EN
        wr_entry = {^{wr_src, wr_data}, wr_src, wr_data};
`else
        wr_entry = {wr_src, wr_data};
`endif
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign pop   = RESULT_VALID & OUT_READY;
    assign do_wr = wr_req & ((state != S_FULL) | pop);
    assign drop  = wr_req & (state == S_FULL) & ~pop;

    // Occupancy tracker, pointers, drop counter and sticky collision flag
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state     <= S_EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            multi_err <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (do_wr && !pop)      count <= count + CNT_ONE;
            else if (pop && !do_wr) count <= count - CNT_ONE;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
            if (multi_hit) multi_err <= 1'b1;
            case (state)
                S_EMPTY:   if (do_wr) state <= S_PARTIAL;
                S_PARTIAL: begin
                    if (do_wr && !pop && count == CNT_ALMOST)  state <= S_FULL;
                    else if (pop && !do_wr && count == CNT_ONE) state <= S_EMPTY;
                end
                S_FULL:    if (pop && !do_wr) state <= S_PARTIAL;
                default:   state <= S_EMPTY;
            endcase
        end
    end

    // Entry storage is deliberately left out of reset
    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= wr_entry;
    end

    assign head         = mem[rd_ptr];
    assign RESULT_VALID = (state != S_EMPTY);
    assign RESULT_OUT   = RESULT_VALID ? head[DATA_WIDTH-1:0] : '0;
    assign RESULT_SRC   = RESULT_VALID ? head[DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
`ifdef ALU_COLLECT_PARITY_EN
    assign RESULT_PAR   = RESULT_VALID & head[DATA_WIDTH+2];
`endif
    assign FIFO_COUNT   = count;
    assign DROP_COUNT   = drop_cnt;
    assign MULTI_ERR    = multi_err;

endmodule
